// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin arbiter that expands atomic read/write transactions
// into the SPI RAM two-word command sequence and returns read data to the owner.
module ram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0]                req_wr_i,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [DATA_WIDTH+1:0]     ram_din_o,
  output logic                      ram_rx_valid_o,
  input  logic [DATA_WIDTH-1:0]     ram_dout_i,
  input  logic                      ram_tx_valid_i
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, CMD_ADDR, CMD_DATA, WAIT_RD, RESP} state_e;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_e        state_q, state_d;
  txn_t          txn_q, txn_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW+1:0] ram_din_q, ram_din_d;
  logic          ram_rx_valid_q, ram_rx_valid_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [1:0]    grant_c;
  logic          gnt_idx_c;
  txn_t          req_txn_c;
  logic [1:0]    owner_oh_c;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_c = req_valid_i;
    if (req_valid_i == 2'b11) begin
      grant_c = last_q ? 2'b01 : 2'b10;
    end
    gnt_idx_c       = grant_c[1];
    req_txn_c.wr    = gnt_idx_c ? req_wr_i[1] : req_wr_i[0];
    req_txn_c.addr  = gnt_idx_c ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0];
    req_txn_c.wdata = gnt_idx_c ? req_wdata_i[2*DW-1:DW] : req_wdata_i[DW-1:0];
    owner_oh_c      = owner_q ? 2'b10 : 2'b01;
  end

  // Outputs are registered from the state being entered, so each appears in its own state's cycle.
  always_comb begin
    state_d        = state_q;
    txn_d          = txn_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    ram_din_d      = '0;
    ram_rx_valid_d = 1'b0;
    rsp_valid_d    = 2'b00;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    req_ready_o    = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (!rst_i) begin
          req_ready_o = grant_c;
        end
        if (req_valid_i != 2'b00) begin
          txn_d          = req_txn_c;
          owner_d        = gnt_idx_c;
          ram_rx_valid_d = 1'b1;
          ram_din_d      = {req_txn_c.wr ? OP_WR_ADDR : OP_RD_ADDR, DW'(req_txn_c.addr)};
          state_d        = CMD_ADDR;
        end
      end
      CMD_ADDR: begin
        ram_rx_valid_d = 1'b1;
        ram_din_d      = txn_q.wr ? {OP_WR_DATA, txn_q.wdata} : {OP_RD_DATA, {DW{1'b0}}};
        state_d        = CMD_DATA;
      end
      CMD_DATA: begin
        if (txn_q.wr) begin
          rsp_valid_d = owner_oh_c;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid_i) begin
          rsp_valid_d = owner_oh_c;
          rsp_rdata_d = ram_dout_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == TMO_LAST) begin
          rsp_valid_d = owner_oh_c;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset favours requester 0 by marking requester 1 as last served.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      txn_q          <= '0;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      cnt_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rsp_valid_q    <= 2'b00;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      txn_q          <= txn_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign ram_din_o      = ram_din_q;
  assign ram_rx_valid_o = ram_rx_valid_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: a behavioural SPI RAM model plus
// queued expectations for every RAM command word and every response pulse.
module tb_ram_access_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  typedef struct { logic [DW+1:0] word; int due; } cmd_exp_t;
  typedef struct { logic [1:0] who; logic [DW-1:0] rdata; logic err; int due; } rsp_exp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata; logic err; } txn_t;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_wr, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_dout;
  logic            rsp_err;
  logic [DW+1:0]   ram_din;
  logic            ram_rx_valid, ram_tx_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rsp = -1;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];
  txn_t     pend0[$];
  txn_t     pend1[$];
  int       grant_log[$];
  int       acc_log[$];

  // RAM model state
  logic [DW-1:0] mem [256];
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  int            pend_cnt = 0;
  int            spur_cnt = 0;
  logic          model_tx = 1'b0;
  logic          model_spur = 1'b0;
  logic [DW-1:0] model_dout = '0;
  logic          model_en;
  logic          spur_on_wr;
  logic          idle_spur;

  assign ram_tx_valid = model_tx | model_spur | idle_spur;
  assign ram_dout     = (model_spur | idle_spur) ? 8'hFF : model_dout;

  ram_access_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_wr_i       (req_wr),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .ram_din_o      (ram_din),
    .ram_rx_valid_o (ram_rx_valid),
    .ram_dout_i     (ram_dout),
    .ram_tx_valid_i (ram_tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM answers a read-data command with one tx_valid pulse in the following cycle.
  always @(negedge clk) begin
    model_tx   = 1'b0;
    model_spur = 1'b0;
    if (spur_cnt > 0) begin
      model_spur = 1'b1;
      spur_cnt--;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        model_tx   = 1'b1;
        model_dout = mem[ra];
      end
    end
    if (ram_rx_valid) begin
      case (ram_din[DW+1:DW])
        2'b00: wa = ram_din[AW-1:0];
        2'b01: begin
          mem[wa] = ram_din[DW-1:0];
          if (spur_on_wr) begin
            model_spur = 1'b1;
            spur_cnt   = 1;
          end
        end
        2'b10: ra = ram_din[AW-1:0];
        default: if (model_en) pend_cnt = 1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitor();
    cmd_exp_t ce;
    rsp_exp_t re;
    if (ram_rx_valid) begin
      chk("cmd_expected", 32'(cmd_q.size() > 0), 1);
      if (cmd_q.size() > 0) begin
        ce = cmd_q.pop_front();
        chk("ram_din", 32'(ram_din), 32'(ce.word));
        chk("cmd_cycle", cyc, ce.due);
      end
    end else begin
      chk("ram_din_idle", 32'(ram_din), 0);
    end
    if (rsp_valid != 2'b00) begin
      chk("rsp_expected", 32'(rsp_q.size() > 0), 1);
      if (rsp_q.size() > 0) begin
        re = rsp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(re.who));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(re.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(re.err));
        chk("rsp_cycle", cyc, re.due);
      end
      if (last_rsp >= 0) chk("rsp_spacing", 32'((cyc - last_rsp) >= 4), 1);
      last_rsp = cyc;
    end
    if (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
      chk("cmd_missing", cyc, cmd_q[0].due);
      void'(cmd_q.pop_front());
    end
    if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
      chk("rsp_missing", cyc, rsp_q[0].due);
      void'(rsp_q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic add(input int who, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err);
    txn_t t;
    t = '{wr: wr, addr: addr, wdata: wdata, rdata: rdata, err: err};
    if (who == 1) pend1.push_back(t);
    else pend0.push_back(t);
  endtask

  task automatic apply();
    req_valid = {pend1.size() > 0, pend0.size() > 0};
    if (pend0.size() > 0) begin
      req_wr[0]          = pend0[0].wr;
      req_addr[AW-1:0]   = pend0[0].addr;
      req_wdata[DW-1:0]  = pend0[0].wdata;
    end
    if (pend1.size() > 0) begin
      req_wr[1]            = pend1[0].wr;
      req_addr[2*AW-1:AW]  = pend1[0].addr;
      req_wdata[2*DW-1:DW] = pend1[0].wdata;
    end
  endtask

  task automatic push_exp(input int g, input txn_t t);
    cmd_exp_t c;
    rsp_exp_t r;
    c.word = t.wr ? {2'b00, t.addr} : {2'b10, t.addr};
    c.due  = cyc + 1;
    cmd_q.push_back(c);
    c.word = t.wr ? {2'b01, t.wdata} : {2'b11, 8'h00};
    c.due  = cyc + 2;
    cmd_q.push_back(c);
    r.who   = (g == 1) ? 2'b10 : 2'b01;
    r.rdata = t.wr ? 8'h00 : t.rdata;
    r.err   = t.err;
    r.due   = t.wr ? cyc + 3 : (t.err ? cyc + 3 + TIMEOUT : cyc + 4);
    rsp_q.push_back(r);
  endtask

  task automatic serve(input int budget);
    int   left;
    int   g;
    txn_t t;
    left = budget;
    while ((pend0.size() + pend1.size()) > 0 && left > 0) begin
      step();
      apply();
      #1;
      if (req_ready != 2'b00) begin
        chk("ready_onehot", 32'($countones(req_ready)), 1);
        chk("ready_subset", 32'(req_ready & ~req_valid), 0);
        g = req_ready[1] ? 1 : 0;
        if (((g == 1) ? pend1.size() : pend0.size()) > 0) begin
          if (g == 1) t = pend1.pop_front();
          else t = pend0.pop_front();
          push_exp(g, t);
          grant_log.push_back(g);
          acc_log.push_back(cyc);
        end
      end
      left--;
    end
    chk("serve_done", 32'(pend0.size() + pend1.size()), 0);
    pend0.delete();
    pend1.delete();
    step();
    req_valid = 2'b00;
  endtask

  task automatic drain(input int budget);
    int left;
    left = budget;
    while ((cmd_q.size() + rsp_q.size()) > 0 && left > 0) begin
      step();
      left--;
    end
    chk("drain", 32'(cmd_q.size() + rsp_q.size()), 0);
    cmd_q.delete();
    rsp_q.delete();
    step();
    step();
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last_rsp = -1;
  endtask

  initial begin
    int t5;
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_wr     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    model_en   = 1'b1;
    spur_on_wr = 1'b0;
    idle_spur  = 1'b0;

    // Reset state, with both requests pending while rst is held
    step();
    step();
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rx_valid", 32'(ram_rx_valid), 0);
    step();
    rst       = 1'b0;
    req_valid = 2'b00;
    step();

    // 1: write then read back
    add(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0);
    serve(20);
    drain(40);
    add(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0);
    serve(20);
    drain(40);

    // 2: both requesters contend continuously, four writes each
    do_reset();
    grant_log.delete();
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      add(0, 1'b1, 8'(8'h40 + i), 8'(8'h10 + i), 8'h00, 1'b0);
      add(1, 1'b1, 8'(8'h80 + i), 8'(8'h20 + i), 8'h00, 1'b0);
    end
    serve(80);
    drain(40);
    chk("t2_grant_count", 32'(grant_log.size()), 8);
    for (int k = 0; k < grant_log.size(); k++) chk("t2_grant_order", 32'(grant_log[k]), 32'(k % 2));
    for (int k = 1; k < acc_log.size(); k++) chk("t2_accept_gap", 32'(acc_log[k] - acc_log[k-1]), 4);

    // 3: read timeout, then a normal read
    model_en = 1'b0;
    add(0, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1);
    serve(20);
    drain(60);
    model_en = 1'b1;
    add(1, 1'b0, 8'h41, 8'h00, 8'h11, 1'b0);
    serve(20);
    drain(40);

    // 4: spurious tx_valid in IDLE and during a write
    idle_spur = 1'b1;
    step();
    idle_spur = 1'b0;
    step();
    step();
    chk("t4_rdata_hold_idle", 32'(rsp_rdata), 32'h11);
    spur_on_wr = 1'b1;
    add(0, 1'b1, 8'h10, 8'h77, 8'h00, 1'b0);
    serve(20);
    drain(40);
    spur_on_wr = 1'b0;
    chk("t4_rdata_after_wr", 32'(rsp_rdata), 0);
    add(0, 1'b0, 8'h10, 8'h00, 8'h77, 1'b0);
    serve(20);
    drain(40);

    // 5: reset during CMD_DATA of a read, then req1 write to the top address
    step();
    req_valid[0]     = 1'b1;
    req_wr[0]        = 1'b0;
    req_addr[AW-1:0] = 8'h3C;
    #1;
    chk("t5_accept", 32'(req_ready), 32'h1);
    t5 = cyc;
    cmd_q.push_back('{word: 10'h23C, due: t5 + 1});
    cmd_q.push_back('{word: 10'h300, due: t5 + 2});
    step();
    req_valid = 2'b00;
    step();
    rst = 1'b1;
    step();
    chk("t5_rx_valid", 32'(ram_rx_valid), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_rsp_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    last_rsp = -1;
    acc_log.delete();
    add(1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0);
    serve(20);
    drain(40);
    chk("t5_reaccept_cycle", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'(t5 + 4));

    // 6: req1 holds an unchanged read for three transactions
    acc_log.delete();
    for (int i = 0; i < 3; i++) add(1, 1'b0, 8'h42, 8'h00, 8'h12, 1'b0);
    serve(40);
    drain(40);
    chk("t6_accept_count", 32'(acc_log.size()), 3);
    for (int k = 1; k < acc_log.size(); k++) chk("t6_accept_gap", 32'(acc_log[k] - acc_log[k-1]), 5);

    // Address boundaries pass through unmodified
    add(0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
    serve(20);
    drain(40);
    add(0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
    add(1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
    serve(40);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Two-requester round-robin arbiter and command sequencer for the single-port SPI RAM.
- Each requester issues one atomic read or write transaction (address + data).
- The block expands each transaction into the RAM's two-word command sequence on din/rx_valid:
  - write: write-address word, then write-data word.
  - read: read-address word, then read-data word.
- For reads, it collects the RAM's dout/tx_valid response and returns it to the owning requester.
- It sits between the SPI-slave-side controller (requester 0), a debug/host port (requester 1) and the RAM.

Parameters:
- ADDR_WIDTH, 8, RAM address width; must equal DATA_WIDTH (RAM din = 2-bit opcode + ADDR_WIDTH).
- DATA_WIDTH, 8, RAM data width.
- TIMEOUT, 16, max cycles spent in WAIT_RD waiting for ram_tx_valid before completing with error; range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester transaction request; held until req_ready.
- req_ready  out  2  one-hot grant/accept pulse, combinational, only in IDLE.
- req_wr  in  2  per-requester op: 1=write, 0=read.
- req_addr  in  2*ADDR_WIDTH  per-requester address; requester i in bits [i*AW +: AW].
- req_wdata  in  2*DATA_WIDTH  per-requester write data; same packing.
- rsp_valid  out  2  one-hot, one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes and errors.
- rsp_err  out  1  read timeout flag, valid with rsp_valid.
- ram_din  out  DATA_WIDTH+2  command word {opcode[1:0], payload}.
- ram_rx_valid  out  1  command word strobe.
- ram_dout  in  DATA_WIDTH  RAM read data.
- ram_tx_valid  in  1  RAM read-data strobe.

Behaviour:
Reset (synchronous rst=1):
- State goes to IDLE; round-robin pointer favours requester 0.
- All registered outputs go to 0: ram_din, ram_rx_valid, rsp_valid, rsp_rdata, rsp_err.
- req_ready is 0 while rst=1.
- Reset mid-transaction aborts it: no rsp_valid is issued, and any partial RAM command is abandoned.

FSM states: IDLE, CMD_ADDR, CMD_DATA, WAIT_RD, RESP.

IDLE:
- If any req_valid is high, grant g by round-robin:
  - If both requesters request, the one not served last wins.
  - A single requester always wins.
- req_ready[g]=1 in this cycle.
- Latch op, addr and wdata of requester g.
- Next state: CMD_ADDR. With no request, stay in IDLE.

CMD_ADDR:
- Registered outputs in this cycle: ram_rx_valid=1, ram_din={wr?2'b00:2'b10, addr}.
- Next state: CMD_DATA.

CMD_DATA:
- ram_rx_valid=1.
- ram_din={2'b01, wdata} for a write; {2'b11, all-zero} for a read.
- Next state: RESP for a write, WAIT_RD for a read (timeout counter cleared).

WAIT_RD:
- ram_rx_valid=0.
- If ram_tx_valid=1: capture ram_dout into rsp_rdata, rsp_err=0, go to RESP.
- Else, if the counter reaches TIMEOUT-1: rsp_rdata=0, rsp_err=1, go to RESP.
- Else increment the counter.

RESP:
- rsp_valid[g]=1 for exactly one cycle.
- Record g as last served; go to IDLE.

Outputs outside the states above:
- ram_rx_valid=0 and ram_din=0 in IDLE, WAIT_RD and RESP.
- rsp_valid=0 in every state except RESP.

Latency, with T = accept cycle:
- Write: ram_rx_valid high at T+1 and T+2; rsp_valid at T+3.
- Read: ram_rx_valid high at T+1 and T+2; WAIT_RD entered at T+3; rsp_valid one cycle after the ram_tx_valid cycle.
  - Minimum: tx_valid at T+3 gives rsp_valid at T+4.
  - Timeout: rsp_valid at T+3+TIMEOUT.

Ordering and boundary rules:
- ram_tx_valid outside WAIT_RD is ignored and never updates rsp_rdata.
- Only one transaction is in flight. After RESP, at least one IDLE cycle elapses before the next accept.
- Max throughput is one write per 4 cycles.
- Requester inputs are sampled only in the accept cycle; later changes have no effect.
- Address 0 and address 2^AW-1 pass through unmodified (no wrap logic).

Test Plan:
1. Write, then read back: req0 write addr=0x3C data=0xA5.
   - Expect ram_din=0x03C then 0x1A5 on consecutive cycles, and rsp_valid=2'b01 at T+3.
   - Then req0 read addr=0x3C: expect ram_din=0x23C then 0x300; model returns 0xA5 → rsp_rdata=0xA5, rsp_err=0.
2. Simultaneous requests: both req_valid high continuously, each doing 4 writes.
   - Expect grants alternating 0,1,0,1,… and the first grant to requester 0 after reset.
   - No two rsp_valid pulses are closer than 4 cycles.
3. Read timeout: RAM model never asserts tx_valid.
   - Expect rsp_valid at T+3+16, rsp_err=1, rsp_rdata=0x00; then the next request is served normally.
4. Spurious tx_valid: pulse ram_tx_valid with ram_dout=0xFF while in IDLE and during a write.
   - Expect no rsp_valid and rsp_rdata unchanged.
   - A following read returns the model's value, not 0xFF.
5. Reset mid-read: assert rst one cycle in CMD_DATA.
   - Expect ram_rx_valid=0 and state IDLE the next cycle, with no rsp_valid.
   - Afterwards, a req1 write to addr=0xFF, data=0x00 completes with ram_din=0x0FF, 0x100.
6. Request held without change: req1 holds req_valid with an unchanged read.
   - Expect a single accept per transaction, with back-to-back transactions separated by one IDLE cycle.
